// File: rtl/pc_counter.sv
// pc_counter -- program counter register for the CPU datapath.
//
// Holds the address of the next instruction. On each rising clock edge it
// clears, loads a jump target, increments by one, or holds. Clear has the
// highest priority, then load, then increment. The +1 path is a ripple chain
// of half adders built from elementary gate cells. wrap_o pulses for one
// cycle alongside the zero that follows an increment from all-ones.
//
// Ports:
//   clk_i    in   1      system clock, rising edge active
//   rst_n_i  in   1      asynchronous active-low reset
//   clr_i    in   1      synchronous clear (highest priority)
//   load_i   in   1      synchronous load of in_i
//   inc_i    in   1      synchronous increment by one
//   in_i     in   WIDTH  jump target, used only when load is selected
//   out_o    out  WIDTH  current program counter, straight from the flops
//   wrap_o   out  1      registered wrap flag

module pc_and2 (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i & b_i;
endmodule

module pc_xor2 (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i ^ b_i;
endmodule

module pc_half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);
  pc_xor2 u_xor (.a_i(a_i), .b_i(b_i), .y_o(sum_o));
  pc_and2 u_and (.a_i(a_i), .b_i(b_i), .y_o(carry_o));
endmodule

module pc_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] inc_sum;
  logic [WIDTH:0]   carry;

  // Carry-in of 1 turns the half-adder chain into a +1 incrementer;
  // carry[WIDTH] is the overflow and only feeds the wrap flag.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_inc
    pc_half_adder u_ha (
      .a_i     (cnt_q[i]),
      .b_i     (carry[i]),
      .sum_o   (inc_sum[i]),
      .carry_o (carry[i+1])
    );
  end

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = in_i;
    end else if (inc_i) begin
      cnt_d  = inc_sum;
      wrap_d = carry[WIDTH];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign out_o  = cnt_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_pc_counter.sv
module tb_pc_counter;

  localparam int W = 16;

  logic         clk_i;
  logic         rst_n_i;
  logic         clr_i;
  logic         load_i;
  logic         inc_i;
  logic [W-1:0] in_i;
  logic [W-1:0] out_o;
  logic         wrap_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [W:0]   sb_q[$];
  logic [W-1:0] m_out;
  logic         m_wrap;

  pc_counter #(.WIDTH(W)) u_dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (clr_i),
    .load_i  (load_i),
    .inc_i   (inc_i),
    .in_i    (in_i),
    .out_o   (out_o),
    .wrap_o  (wrap_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Compares {wrap, out} packed values.
  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got wrap=%b out=%h, expected wrap=%b out=%h",
               tag, obs[W], obs[W-1:0], exp[W], exp[W-1:0]);
    end
  endtask

  // Drives one cycle of controls, pushes the model's expectation, then
  // pops it and compares against the DUT after the edge.
  task automatic step(input string tag, input logic c, input logic l,
                      input logic i, input logic [W-1:0] d);
    logic [W:0] exp;
    @(negedge clk_i);
    clr_i = c; load_i = l; inc_i = i; in_i = d;
    if (c) begin
      m_out = '0; m_wrap = 1'b0;
    end else if (l) begin
      m_out = d; m_wrap = 1'b0;
    end else if (i) begin
      m_wrap = (m_out == {W{1'b1}});
      m_out  = m_out + 1'b1;
    end else begin
      m_wrap = 1'b0;
    end
    sb_q.push_back({m_wrap, m_out});
    @(posedge clk_i);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, {wrap_o, out_o}, {1'b1, {W{1'b1}}} ^ {wrap_o, out_o});
    end else begin
      exp = sb_q.pop_front();
      chk(tag, {wrap_o, out_o}, exp);
    end
  endtask

  task automatic idle_ctl();
    clr_i = 1'b0; load_i = 1'b0; inc_i = 1'b0;
  endtask

  initial begin
    rst_n_i = 1'b0;
    clr_i   = 1'($urandom_range(0, 1));
    load_i  = 1'($urandom_range(0, 1));
    inc_i   = 1'($urandom_range(0, 1));
    in_i    = 16'hBEEF;
    m_out   = '0;
    m_wrap  = 1'b0;

    // Reset takes effect before any clock edge.
    #1;
    chk("rst_no_clk", {wrap_o, out_o}, 17'h0);
    repeat (3) begin
      @(negedge clk_i);
      clr_i  = 1'($urandom_range(0, 1));
      load_i = 1'($urandom_range(0, 1));
      inc_i  = 1'($urandom_range(0, 1));
    end
    #1;
    chk("rst_hold", {wrap_o, out_o}, 17'h0);
    @(negedge clk_i);
    idle_ctl();
    rst_n_i = 1'b1;

    step("inc1", 0, 0, 1, 16'hBEEF); chk("inc1_c", {wrap_o, out_o}, {1'b0, 16'h0001});
    step("inc2", 0, 0, 1, 16'hBEEF); chk("inc2_c", {wrap_o, out_o}, {1'b0, 16'h0002});
    step("inc3", 0, 0, 1, 16'hBEEF); chk("inc3_c", {wrap_o, out_o}, {1'b0, 16'h0003});

    step("load",  0, 1, 0, 16'h1234); chk("load_c",  {wrap_o, out_o}, {1'b0, 16'h1234});
    step("hold1", 0, 0, 0, 16'hAAAA); chk("hold1_c", {wrap_o, out_o}, {1'b0, 16'h1234});
    step("hold2", 0, 0, 0, 16'h5555); chk("hold2_c", {wrap_o, out_o}, {1'b0, 16'h1234});

    step("ld_fffe", 0, 1, 0, 16'hFFFE);
    step("wr_a", 0, 0, 1, 16'h0); chk("wr_a_c", {wrap_o, out_o}, {1'b0, 16'hFFFF});
    step("wr_b", 0, 0, 1, 16'h0); chk("wr_b_c", {wrap_o, out_o}, {1'b1, 16'h0000});
    step("wr_c", 0, 0, 1, 16'h0); chk("wr_c_c", {wrap_o, out_o}, {1'b0, 16'h0001});

    step("pri_li",  0, 1, 1, 16'hFFFF); chk("pri_li_c",  {wrap_o, out_o}, {1'b0, 16'hFFFF});
    step("pri_cli", 1, 1, 1, 16'h4321); chk("pri_cli_c", {wrap_o, out_o}, {1'b0, 16'h0000});
    step("pri_rl",  0, 1, 0, 16'hFFFF);
    step("pri_inc", 0, 0, 1, 16'h0);    chk("pri_inc_c", {wrap_o, out_o}, {1'b1, 16'h0000});
    // Clear while all-ones and inc asserted: no wrap.
    step("pri_rl2", 0, 1, 0, 16'hFFFF);
    step("pri_ci",  1, 0, 1, 16'h0);    chk("pri_ci_c",  {wrap_o, out_o}, {1'b0, 16'h0000});

    step("ar_ld", 0, 1, 0, 16'h0003);
    step("ar_i1", 0, 0, 1, 16'h0);
    step("ar_i2", 0, 0, 1, 16'h0); chk("ar_5", {wrap_o, out_o}, {1'b0, 16'h0005});
    @(negedge clk_i);
    inc_i = 1'b1;
    #1 rst_n_i = 1'b0;
    #1 chk("ar_async", {wrap_o, out_o}, 17'h0);
    m_out = '0; m_wrap = 1'b0;
    #1 rst_n_i = 1'b1;
    idle_ctl();
    step("ar_inc", 0, 0, 1, 16'h0); chk("ar_inc_c", {wrap_o, out_o}, {1'b0, 16'h0001});

    step("cr_l1", 0, 1, 0, 16'h00FF);
    step("cr_i1", 0, 0, 1, 16'h0); chk("cr_0100", {wrap_o, out_o}, {1'b0, 16'h0100});
    step("cr_l2", 0, 1, 0, 16'h0FFF);
    step("cr_i2", 0, 0, 1, 16'h0); chk("cr_1000", {wrap_o, out_o}, {1'b0, 16'h1000});
    step("cr_l3", 0, 1, 0, 16'h7FFF);
    step("cr_i3", 0, 0, 1, 16'h0); chk("cr_8000", {wrap_o, out_o}, {1'b0, 16'h8000});

    // Random traffic biased toward increments, with occasional near-wrap loads.
    for (int k = 0; k < 300; k++) begin
      logic [W-1:0] d;
      d = (($urandom_range(0, 3) == 0) ? 16'hFFF0 | 16'($urandom_range(0, 15))
                                        : 16'($urandom));
      step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0), d);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
